// File: rtl/conv_pkg.sv
// Shared definitions for the conv_pool result path: pixel/tile widths and
// the packed 4x4-tile word carried from the packer to the memory writer.
package conv_pkg;

  localparam int PIX_W    = 8;
  localparam int TILE_PIX = 16;
  localparam int TILE_W   = PIX_W * TILE_PIX;
  localparam int ADDR_W   = 16;
  localparam int WADDR_W  = 12;

  typedef struct packed {
    logic [WADDR_W-1:0]  waddr;
    logic [TILE_PIX-1:0] be;
    logic [TILE_W-1:0]   data;
  } packed_word_t;

endpackage

// File: rtl/conv_sync_fifo.sv
// Single-clock FIFO of packed tile words. A push while full is only taken
// when a pop happens on the same edge; the head reads as zero when empty.
module conv_sync_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  packed_word_t               din,
  input  logic                       pop,
  output packed_word_t               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  packed_word_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible past the empty mask.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/conv_result_packer.sv
// Packs the byte-wide conv_pool result stream into 128-bit 4x4 tile words
// and queues them for the memory writer; drops are flagged, never stalled.
module conv_result_packer
  import conv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LANES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_we,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [PIX_W-1:0]           in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TILE_W-1:0]          out_data,
  output logic [WADDR_W-1:0]         out_waddr,
  output logic [LANES-1:0]           out_be,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  logic                act_q, act_d;
  logic [WADDR_W-1:0]  waddr_q, waddr_d;
  logic [TILE_W-1:0]   data_q, data_d;
  logic [LANES-1:0]    be_q, be_d;
  logic                overflow_q;

  logic [3:0]          lane;
  logic [WADDR_W-1:0]  in_word;
  logic                hit, change;
  logic [TILE_W-1:0]   open_data, merge_data;
  logic [LANES-1:0]    open_be, merge_be;
  logic                push, pop, full, empty;
  packed_word_t        push_word, head;

  assign lane    = in_addr[3:0];
  assign in_word = in_addr[ADDR_W-1:4];
  assign hit     = in_we && (!act_q || (waddr_q == in_word));
  assign change  = in_we && act_q && (waddr_q != in_word);

  // open_* is the incoming byte alone; merge_* overlays it on the live word.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign open_be[gi]              = (lane == 4'(gi));
    assign open_data[8*gi +: 8]     = open_be[gi] ? in_data : 8'h00;
    assign merge_be[gi]             = open_be[gi] | (act_q & be_q[gi]);
    assign merge_data[8*gi +: 8]    = (open_be[gi] || !act_q) ? open_data[8*gi +: 8]
                                                              : data_q[8*gi +: 8];
  end

  always_comb begin
    act_d     = act_q;
    waddr_d   = waddr_q;
    data_d    = data_q;
    be_d      = be_q;
    push      = 1'b0;
    push_word = '{waddr: waddr_q, be: be_q, data: data_q};
    if (change) begin
      push    = 1'b1;
      act_d   = 1'b1;
      waddr_d = in_word;
      data_d  = open_data;
      be_d    = open_be;
    end else if (hit) begin
      if (merge_be == '1 || flush) begin
        push      = 1'b1;
        push_word = '{waddr: in_word, be: merge_be, data: merge_data};
        act_d     = 1'b0;
      end else begin
        act_d   = 1'b1;
        waddr_d = in_word;
        data_d  = merge_data;
        be_d    = merge_be;
      end
    end else if (flush && act_q) begin
      push  = 1'b1;
      act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q      <= 1'b0;
      waddr_q    <= '0;
      data_q     <= '0;
      be_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      act_q   <= act_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  conv_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head.data;
  assign out_waddr = head.waddr;
  assign out_be    = head.be;
  assign overflow  = overflow_q;

endmodule
